// File: rtl/ddr_cmd_monitor.sv
// ddr_cmd_monitor: passive DDR4 command-bus monitor.
//
// Samples cs_n/act_n/adr/ba/bg on every rising clk edge, decodes the command
// class, tracks per-bank open state and open row, resolves the full row/column
// of each RD/WR and keeps saturating event counters plus a protocol-error flag.
// All outputs are registered on the edge that samples the command.
//
// Ports:
//   clk, rst_n            command clock, async active-low reset
//   cs_n, act_n, adr      command/address pins (adr[ADDR_W-1 -: 3] = RAS/CAS/WE)
//   ba, bg                bank address / bank group; bank index is {ba,bg}
//   cnt_clr               synchronous clear of counters and err_sticky
//   cmd_vld/cmd_type      one-cycle decoded-command pulse and its class
//   bank_idx              {ba,bg} of the last decoded command
//   row_adr/col_adr       resolved row/column of last ACT or RD/WR
//   *_cnt                 saturating event counters (CNT_W bits each)
//   err/err_sticky        protocol-error pulse and sticky flag
//   bank_open             per-bank open bitmap
//   bank_acc_cnt          per-bank RD+WR counters (only with DDR_MON_BANK_CNT_EN)
//
// Build option: define DDR_MON_BANK_CNT_EN to add bank_acc_cnt.

// Per-bank state: open flag, open row and the row most recently closed.
module ddr_cmd_monitor_bank #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act,
  input  logic              pre,
  input  logic [ADDR_W-1:0] adr,
  output logic              open,
  output logic [ADDR_W-1:0] open_row,
  output logic              reopen
);
  logic [ADDR_W-1:0] last_row;
  logic              last_vld;

  // Compared against pre-update state, so an ACT that overwrites an open
  // bank still checks the row closed by the previous PRE.
  assign reopen = act && last_vld && (last_row == adr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open     <= 1'b0;
      open_row <= '0;
      last_row <= '0;
      last_vld <= 1'b0;
    end else if (act) begin
      open     <= 1'b1;
      open_row <= adr;
    end else if (pre && open) begin
      // PRE to a closed bank leaves last_row untouched.
      open     <= 1'b0;
      last_row <= open_row;
      last_vld <= 1'b1;
    end
  end
endmodule

// Saturating event counter with synchronous clear taking priority.
module ddr_cmd_monitor_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && !(&cnt))   cnt <= cnt + CNT_W'(1);
  end
endmodule

module ddr_cmd_monitor #(
  parameter int ADDR_W = 17,
  parameter int BA_W   = 2,
  parameter int BG_W   = 2,
  parameter int COL_W  = 10,
  parameter int CNT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs_n,
  input  logic                          act_n,
  input  logic [ADDR_W-1:0]             adr,
  input  logic [BA_W-1:0]               ba,
  input  logic [BG_W-1:0]               bg,
  input  logic                          cnt_clr,
  output logic                          cmd_vld,
  output logic [2:0]                    cmd_type,
  output logic [BA_W+BG_W-1:0]          bank_idx,
  output logic [ADDR_W-1:0]             row_adr,
  output logic [COL_W-1:0]              col_adr,
  output logic [CNT_W-1:0]              act_cnt,
  output logic [CNT_W-1:0]              rd_cnt,
  output logic [CNT_W-1:0]              wr_cnt,
  output logic [CNT_W-1:0]              pre_cnt,
  output logic [CNT_W-1:0]              prea_cnt,
  output logic [CNT_W-1:0]              ref_cnt,
  output logic [CNT_W-1:0]              mrs_cnt,
  output logic [CNT_W-1:0]              oth_cnt,
  output logic [CNT_W-1:0]              reopen_cnt,
  output logic [CNT_W-1:0]              err_cnt,
  output logic                          err,
  output logic                          err_sticky,
  output logic [(1<<(BA_W+BG_W))-1:0]   bank_open
`ifdef DDR_MON_BANK_CNT_EN
  ,
  output logic [(1<<(BA_W+BG_W))*CNT_W-1:0] bank_acc_cnt
`endif
);
  localparam int BK_W  = BA_W + BG_W;
  localparam int NB    = 1 << BK_W;
  localparam int NEV   = 10;

  localparam logic [2:0] C_ACT  = 3'd0;
  localparam logic [2:0] C_RD   = 3'd1;
  localparam logic [2:0] C_WR   = 3'd2;
  localparam logic [2:0] C_PRE  = 3'd3;
  localparam logic [2:0] C_PREA = 3'd4;
  localparam logic [2:0] C_REF  = 3'd5;
  localparam logic [2:0] C_MRS  = 3'd6;
  localparam logic [2:0] C_OTH  = 3'd7;

  logic [2:0]        rcw;
  logic              hit;
  logic [2:0]        cls;
  logic [BK_W-1:0]   bk;
  logic [NB-1:0]     sel;
  logic [NB-1:0]     reopen_v;
  logic [ADDR_W-1:0] open_row [NB];
  logic              rw_hit;
  logic              cur_open;
  logic [ADDR_W-1:0] cur_row;
  logic              err_now;
  logic [NEV-1:0]    ev;
  logic [CNT_W-1:0]  cnt_q [NEV];

  assign rcw = adr[ADDR_W-1 -: 3];
  assign bk  = {ba, bg};

  // Decode. An X/Z on cs_n makes the if-condition non-true, so it falls
  // through as a deselect in simulation.
  always_comb begin
    hit = 1'b0;
    cls = C_OTH;
    if (!cs_n) begin
      hit = 1'b1;
      if (!act_n) cls = C_ACT;
      else begin
        case (rcw)
          3'b000:  cls = C_MRS;
          3'b001:  cls = C_REF;
          3'b010:  cls = adr[10] ? C_PREA : C_PRE;
          3'b100:  cls = C_WR;
          3'b101:  cls = C_RD;
          3'b111:  hit = 1'b0;   // NOP
          default: cls = C_OTH;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_bank
    assign sel[i] = (bk == BK_W'(i));
    ddr_cmd_monitor_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .act      (hit && (cls == C_ACT) && sel[i]),
      .pre      (hit && (((cls == C_PRE) && sel[i]) || (cls == C_PREA))),
      .adr      (adr),
      .open     (bank_open[i]),
      .open_row (open_row[i]),
      .reopen   (reopen_v[i])
    );
  end

  assign rw_hit   = hit && ((cls == C_RD) || (cls == C_WR));
  assign cur_open = bank_open[bk];
  assign cur_row  = open_row[bk];

  assign err_now = hit && (((cls == C_ACT) && cur_open) ||
                           (((cls == C_RD) || (cls == C_WR)) && !cur_open) ||
                           ((cls == C_REF) && (|bank_open)));

  // Events 0..7 follow the cmd_type encoding; 8 = reopen, 9 = error.
  for (genvar k = 0; k < 8; k++) begin : g_ev
    assign ev[k] = hit && (cls == 3'(k));
  end
  assign ev[8] = |reopen_v;
  assign ev[9] = err_now;

  for (genvar k = 0; k < NEV; k++) begin : g_cnt
    ddr_cmd_monitor_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (ev[k]),
      .cnt   (cnt_q[k])
    );
  end

  assign act_cnt    = cnt_q[0];
  assign rd_cnt     = cnt_q[1];
  assign wr_cnt     = cnt_q[2];
  assign pre_cnt    = cnt_q[3];
  assign prea_cnt   = cnt_q[4];
  assign ref_cnt    = cnt_q[5];
  assign mrs_cnt    = cnt_q[6];
  assign oth_cnt    = cnt_q[7];
  assign reopen_cnt = cnt_q[8];
  assign err_cnt    = cnt_q[9];

`ifdef DDR_MON_BANK_CNT_EN
  for (genvar i = 0; i < NB; i++) begin : g_acc
    ddr_cmd_monitor_cnt #(.CNT_W(CNT_W)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (rw_hit && sel[i]),
      .cnt   (bank_acc_cnt[i*CNT_W +: CNT_W])
    );
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld    <= 1'b0;
      cmd_type   <= '0;
      bank_idx   <= '0;
      row_adr    <= '0;
      col_adr    <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      cmd_vld <= hit;
      err     <= err_now;
      if (cnt_clr)      err_sticky <= 1'b0;
      else if (err_now) err_sticky <= 1'b1;
      if (hit) begin
        cmd_type <= cls;
        bank_idx <= bk;
      end
      if (hit && (cls == C_ACT)) begin
        row_adr <= adr;
      end else if (rw_hit) begin
        // Access to a closed bank has no valid row: flag it with all-ones.
        row_adr <= cur_open ? cur_row : '1;
        col_adr <= adr[COL_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_ddr_cmd_monitor.sv
// Self-checking bench for ddr_cmd_monitor. Two instances share the stimulus:
// dut (CNT_W=32) and dut4 (CNT_W=4, for saturation). A behavioural model
// tracks bank state and unbounded event totals; expected counter values are
// those totals clipped to each instance's maximum.
module tb_ddr_cmd_monitor;
  localparam int NB = 16;
  localparam logic [16:0] RD   = 17'h14000;
  localparam logic [16:0] WR   = 17'h10000;
  localparam logic [16:0] PRE  = 17'h08000;
  localparam logic [16:0] PREA = 17'h08400;
  localparam logic [16:0] REF  = 17'h04000;
  localparam logic [16:0] MRS  = 17'h00000;
  localparam logic [16:0] NOP  = 17'h1C000;

  logic        clk = 1'b0;
  logic        rst_n, cs_n, act_n, cnt_clr;
  logic [16:0] adr;
  logic [1:0]  ba, bg;

  logic        cmd_vld, err, err_sticky;
  logic [2:0]  cmd_type;
  logic [3:0]  bank_idx;
  logic [16:0] row_adr;
  logic [9:0]  col_adr;
  logic [15:0] bank_open;
  logic [31:0] cnt [10];

  logic        s_vld, s_err, s_sticky;
  logic [2:0]  s_type;
  logic [3:0]  s_bank;
  logic [16:0] s_row;
  logic [9:0]  s_col;
  logic [15:0] s_open;
  logic [3:0]  s_cnt [10];
`ifdef DDR_MON_BANK_CNT_EN
  logic [NB*32-1:0] bank_acc_cnt;
  logic [NB*4-1:0]  s_acc;
`endif

  int passed = 0;
  int total  = 0;

  // reference model state
  bit          m_open [NB];
  logic [16:0] m_orow [NB];
  logic [16:0] m_lrow [NB];
  bit          m_lvld [NB];
  longint      m_cnt  [10];
  longint      m_acc  [NB];
  bit          e_vld, e_err, e_sticky;
  logic [2:0]  e_type;
  logic [3:0]  e_bank;
  logic [16:0] e_row;
  logic [9:0]  e_col;

  always #5 clk = ~clk;

  ddr_cmd_monitor dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .act_n(act_n), .adr(adr), .ba(ba), .bg(bg),
    .cnt_clr(cnt_clr), .cmd_vld(cmd_vld), .cmd_type(cmd_type), .bank_idx(bank_idx),
    .row_adr(row_adr), .col_adr(col_adr),
    .act_cnt(cnt[0]), .rd_cnt(cnt[1]), .wr_cnt(cnt[2]), .pre_cnt(cnt[3]),
    .prea_cnt(cnt[4]), .ref_cnt(cnt[5]), .mrs_cnt(cnt[6]), .oth_cnt(cnt[7]),
    .reopen_cnt(cnt[8]), .err_cnt(cnt[9]), .err(err), .err_sticky(err_sticky),
    .bank_open(bank_open)
`ifdef DDR_MON_BANK_CNT_EN
    , .bank_acc_cnt(bank_acc_cnt)
`endif
  );

  ddr_cmd_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .act_n(act_n), .adr(adr), .ba(ba), .bg(bg),
    .cnt_clr(cnt_clr), .cmd_vld(s_vld), .cmd_type(s_type), .bank_idx(s_bank),
    .row_adr(s_row), .col_adr(s_col),
    .act_cnt(s_cnt[0]), .rd_cnt(s_cnt[1]), .wr_cnt(s_cnt[2]), .pre_cnt(s_cnt[3]),
    .prea_cnt(s_cnt[4]), .ref_cnt(s_cnt[5]), .mrs_cnt(s_cnt[6]), .oth_cnt(s_cnt[7]),
    .reopen_cnt(s_cnt[8]), .err_cnt(s_cnt[9]), .err(s_err), .err_sticky(s_sticky),
    .bank_open(s_open)
`ifdef DDR_MON_BANK_CNT_EN
    , .bank_acc_cnt(s_acc)
`endif
  );

  function automatic longint cap(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [15:0] exp_open();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i] = m_open[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 0; m_orow[i] = '0; m_lrow[i] = '0; m_lvld[i] = 0; m_acc[i] = 0;
    end
    for (int k = 0; k < 10; k++) m_cnt[k] = 0;
    e_vld = 0; e_err = 0; e_sticky = 0; e_type = '0; e_bank = '0; e_row = '0; e_col = '0;
  endtask

  task automatic close_bank(input int b);
    if (m_open[b]) begin
      m_open[b] = 0; m_lrow[b] = m_orow[b]; m_lvld[b] = 1;
    end
  endtask

  // Applies the command currently on the pins to the model.
  task automatic model_step();
    int t, b;
    bit v, e;
    v = 0; e = 0; t = 7; b = int'({ba, bg});
    if (cs_n === 1'b0) begin
      v = 1;
      if (act_n == 1'b0) t = 0;
      else begin
        case (adr[16:14])
          3'b000: t = 6;
          3'b001: t = 5;
          3'b010: t = adr[10] ? 4 : 3;
          3'b100: t = 2;
          3'b101: t = 1;
          3'b111: v = 0;
          default: t = 7;
        endcase
      end
    end
    if (v) begin
      m_cnt[t]++;
      e_type = 3'(t);
      e_bank = 4'(b);
      case (t)
        0: begin
          e = m_open[b];
          if (m_lvld[b] && m_lrow[b] == adr) m_cnt[8]++;
          m_open[b] = 1; m_orow[b] = adr; e_row = adr;
        end
        1, 2: begin
          e = !m_open[b];
          e_row = m_open[b] ? m_orow[b] : 17'h1FFFF;
          e_col = adr[9:0];
          m_acc[b]++;
        end
        3: close_bank(b);
        4: for (int i = 0; i < NB; i++) close_bank(i);
        5: for (int i = 0; i < NB; i++) if (m_open[i]) e = 1;
        default: ;
      endcase
    end
    if (e) begin m_cnt[9]++; e_sticky = 1; end
    e_vld = v; e_err = e;
    if (cnt_clr) begin
      for (int k = 0; k < 10; k++) m_cnt[k] = 0;
      for (int i = 0; i < NB; i++) m_acc[i] = 0;
      e_sticky = 0;
    end
  endtask

  // One command cycle: drive at negedge, sample 1 ns after the posedge,
  // then return the pins to deselect.
  task automatic issue(input logic c, input logic a, input logic [16:0] ad,
                       input logic [3:0] bk, input logic clr);
    @(negedge clk);
    cs_n = c; act_n = a; adr = ad; {ba, bg} = bk; cnt_clr = clr;
    model_step();
    @(posedge clk); #1;
    cs_n = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic cmd(input logic [16:0] ad, input logic [3:0] bk);
    issue(1'b0, 1'b1, ad, bk, 1'b0);
  endtask

  task automatic act(input logic [16:0] row, input logic [3:0] bk);
    issue(1'b0, 1'b0, row, bk, 1'b0);
  endtask

  task automatic clr();
    issue(1'b1, 1'b1, 17'h0, 4'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; act_n = 1'b1; adr = '0; ba = '0; bg = '0; cnt_clr = 1'b0;
    model_reset();
    #12;
    total++; if (cmd_vld !== 1'b0) $display("FAIL reset_vld got %0b want 0", cmd_vld); else passed++;
    total++; if (bank_open !== 16'h0) $display("FAIL reset_open got %h want 0", bank_open); else passed++;
    total++; if (err_sticky !== 1'b0 || err !== 1'b0) $display("FAIL reset_err got %0b%0b want 00", err, err_sticky); else passed++;
    total++; if (row_adr !== 17'h0 || col_adr !== 10'h0) $display("FAIL reset_adr got %h/%h want 0/0", row_adr, col_adr); else passed++;
    for (int k = 0; k < 10; k++) begin
      total++; if (cnt[k] !== 32'h0) $display("FAIL reset_cnt%0d got %0d want 0", k, cnt[k]); else passed++;
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    act(17'h1234, 4'd6);
    total++; if (cmd_vld !== 1'b1 || cmd_type !== 3'd0) $display("FAIL basic_act got vld %0b type %0d want 1/0", cmd_vld, cmd_type); else passed++;
    total++; if (bank_idx !== 4'd6) $display("FAIL basic_bank got %0d want 6", bank_idx); else passed++;
    total++; if (bank_open !== 16'h0040) $display("FAIL basic_open got %h want 0040", bank_open); else passed++;
    cmd(RD | 17'h05A, 4'd6);
    total++; if (cmd_type !== 3'd1) $display("FAIL basic_rd_type got %0d want 1", cmd_type); else passed++;
    total++; if (row_adr !== 17'h1234 || col_adr !== 10'h05A) $display("FAIL basic_rd_adr got %h/%h want 1234/05a", row_adr, col_adr); else passed++;
    total++; if (cnt[0] !== 32'd1 || cnt[1] !== 32'd1) $display("FAIL basic_cnt got act %0d rd %0d want 1/1", cnt[0], cnt[1]); else passed++;
    total++; if (err !== 1'b0) $display("FAIL basic_err got %0b want 0", err); else passed++;
  endtask

  task automatic test_reopen();
    clr();
    act(17'h0100, 4'd0);
    cmd(PRE, 4'd0);
    total++; if (bank_open[0] !== 1'b0) $display("FAIL reopen_pre got %0b want 0", bank_open[0]); else passed++;
    act(17'h0100, 4'd0);
    total++; if (cnt[8] !== 32'd1 || err !== 1'b0) $display("FAIL reopen_cnt got %0d err %0b want 1/0", cnt[8], err); else passed++;
    act(17'h0200, 4'd0);
    total++; if (err !== 1'b1 || cnt[9] !== 32'd1) $display("FAIL reopen_dbl_act got err %0b cnt %0d want 1/1", err, cnt[9]); else passed++;
    total++; if (cnt[8] !== 32'd1) $display("FAIL reopen_cnt2 got %0d want 1", cnt[8]); else passed++;
    cmd(RD, 4'd0);
    total++; if (row_adr !== 17'h0200) $display("FAIL reopen_row got %h want 0200", row_adr); else passed++;
  endtask

  task automatic test_prea_ref();
    clr();
    act(17'h0033, 4'd3);
    act(17'h0099, 4'd9);
    cmd(PREA, 4'd0);
    total++; if (cnt[4] !== 32'd1 || bank_open !== 16'h0) $display("FAIL prea got cnt %0d open %h want 1/0000", cnt[4], bank_open); else passed++;
    cmd(REF, 4'd0);
    total++; if (cnt[5] !== 32'd1 || cnt[9] !== 32'd0 || err !== 1'b0) $display("FAIL ref_closed got ref %0d errc %0d err %0b want 1/0/0", cnt[5], cnt[9], err); else passed++;
    act(17'h0034, 4'd3);
    cmd(REF, 4'd0);
    total++; if (err !== 1'b1 || err_sticky !== 1'b1 || cnt[9] !== 32'd1) $display("FAIL ref_open got err %0b sticky %0b cnt %0d want 1/1/1", err, err_sticky, cnt[9]); else passed++;
    cmd(NOP, 4'd0);
    total++; if (err !== 1'b0 || err_sticky !== 1'b1 || cmd_vld !== 1'b0) $display("FAIL err_pulse got err %0b sticky %0b vld %0b want 0/1/0", err, err_sticky, cmd_vld); else passed++;
  endtask

  task automatic test_closed_access();
    clr();
    total++; if (err_sticky !== 1'b0) $display("FAIL clr_sticky got %0b want 0", err_sticky); else passed++;
    cmd(WR | 17'h011, 4'd5);
    total++; if (cnt[2] !== 32'd1 || cnt[9] !== 32'd1) $display("FAIL wr_closed got wr %0d err %0d want 1/1", cnt[2], cnt[9]); else passed++;
    total++; if (row_adr !== 17'h1FFFF || col_adr !== 10'h011) $display("FAIL wr_closed_adr got %h/%h want 1ffff/011", row_adr, col_adr); else passed++;
    issue(1'b0, 1'b1, RD, 4'd5, 1'b1);
    total++; if (cmd_vld !== 1'b1 || cmd_type !== 3'd1) $display("FAIL clr_rd got vld %0b type %0d want 1/1", cmd_vld, cmd_type); else passed++;
    total++; if (err_sticky !== 1'b0) $display("FAIL clr_rd_sticky got %0b want 0", err_sticky); else passed++;
    for (int k = 0; k < 10; k++) begin
      total++; if (cnt[k] !== 32'h0) $display("FAIL clr_rd_cnt%0d got %0d want 0", k, cnt[k]); else passed++;
    end
  endtask

  task automatic test_saturate();
    int pulses;
    clr();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      issue((i % 2) ? 1'b1 : 1'b0, 1'b1, NOP, 4'(i), 1'b0);
      pulses += int'(cmd_vld);
    end
    total++; if (pulses !== 0) $display("FAIL nop_pulses got %0d want 0", pulses); else passed++;
    for (int i = 0; i < 17; i++) begin
      cmd(MRS, 4'd0);
      pulses += int'(cmd_vld);
    end
    total++; if (pulses !== 17) $display("FAIL mrs_pulses got %0d want 17", pulses); else passed++;
    total++; if (s_cnt[6] !== 4'd15) $display("FAIL mrs_sat got %0d want 15", s_cnt[6]); else passed++;
    total++; if (cnt[6] !== 32'd17) $display("FAIL mrs_wide got %0d want 17", cnt[6]); else passed++;
  endtask

  task automatic test_random();
    logic [16:0] a;
    for (int n = 0; n < 400; n++) begin
      a = {3'($urandom_range(0, 7)), 14'($urandom_range(0, 3)) | (14'($urandom_range(0, 1)) << 10)};
      issue(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), a,
            4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
      total++; if (cmd_vld !== e_vld) $display("FAIL rnd_vld n=%0d got %0b want %0b", n, cmd_vld, e_vld); else passed++;
      if (e_vld) begin
        total++; if (cmd_type !== e_type || bank_idx !== e_bank) $display("FAIL rnd_type n=%0d got %0d/%0d want %0d/%0d", n, cmd_type, bank_idx, e_type, e_bank); else passed++;
      end
      total++; if (row_adr !== e_row || col_adr !== e_col) $display("FAIL rnd_adr n=%0d got %h/%h want %h/%h", n, row_adr, col_adr, e_row, e_col); else passed++;
      total++; if (err !== e_err || err_sticky !== e_sticky) $display("FAIL rnd_err n=%0d got %0b%0b want %0b%0b", n, err, err_sticky, e_err, e_sticky); else passed++;
      total++; if (bank_open !== exp_open()) $display("FAIL rnd_open n=%0d got %h want %h", n, bank_open, exp_open()); else passed++;
      for (int k = 0; k < 10; k++) begin
        total++; if (cnt[k] !== 32'(cap(m_cnt[k], 64'hFFFF_FFFF))) $display("FAIL rnd_cnt%0d n=%0d got %0d want %0d", k, n, cnt[k], m_cnt[k]); else passed++;
        total++; if (s_cnt[k] !== 4'(cap(m_cnt[k], 15))) $display("FAIL rnd_sat%0d n=%0d got %0d want %0d", k, n, s_cnt[k], cap(m_cnt[k], 15)); else passed++;
      end
`ifdef DDR_MON_BANK_CNT_EN
      for (int i = 0; i < NB; i++) begin
        total++; if (bank_acc_cnt[i*32 +: 32] !== 32'(m_acc[i])) $display("FAIL rnd_acc%0d n=%0d got %0d want %0d", i, n, bank_acc_cnt[i*32 +: 32], m_acc[i]); else passed++;
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    clr();
    act(17'h0222, 4'd2);
    act(17'h0777, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    total++; if (cmd_vld !== 1'b0 || bank_open !== 16'h0) $display("FAIL arst_out got vld %0b open %h want 0/0000", cmd_vld, bank_open); else passed++;
    total++; if (cnt[0] !== 32'h0 || row_adr !== 17'h0) $display("FAIL arst_cnt got act %0d row %h want 0/0", cnt[0], row_adr); else passed++;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cmd(RD, 4'd2);
    total++; if (err !== 1'b1 || row_adr !== 17'h1FFFF) $display("FAIL arst_rd got err %0b row %h want 1/1ffff", err, row_adr); else passed++;
    total++; if (cnt[1] !== 32'd1 || cnt[9] !== 32'd1) $display("FAIL arst_rd_cnt got rd %0d err %0d want 1/1", cnt[1], cnt[9]); else passed++;
  endtask

`ifdef DDR_MON_BANK_CNT_EN
  task automatic test_bank_acc();
    clr();
    act(17'h0300, 4'd6);
    for (int i = 0; i < 3; i++) cmd(RD | 17'(i), 4'd6);
    for (int i = 0; i < 2; i++) cmd(WR | 17'(i), 4'd6);
    total++; if (bank_acc_cnt[6*32 +: 32] !== 32'd5) $display("FAIL acc6 got %0d want 5", bank_acc_cnt[6*32 +: 32]); else passed++;
    total++; if (s_acc[6*4 +: 4] !== 4'd5) $display("FAIL acc6_sat got %0d want 5", s_acc[6*4 +: 4]); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reopen();
    test_prea_ref();
    test_closed_access();
    test_saturate();
    test_random();
    test_async_reset();
`ifdef DDR_MON_BANK_CNT_EN
    test_bank_acc();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
